// File: rtl/reaction_ctrl.sv
// reaction_ctrl -- sequencing FSM for the reaction-time game.
//
// Takes debounced single-cycle button pulses. On start it waits a pseudo-random
// fore-period, then lights led0 and counts the response time in milliseconds
// as four BCD digits. A display mode goes to the seven-segment driver.
//
// Parameters
//   CLK_PER_MS    clk cycles per 1 ms tick (>= 2)
//   MIN_DELAY_MS  fixed part of the fore-period, ms
//   RAND_BITS     random part of the fore-period = lfsr[RAND_BITS-1:0] ms
//   MAX_MS        response timeout, ms (<= 9999)
//
// Ports
//   clk    system clock
//   reset  asynchronous, active-high reset
//   start  1-cycle pulse, begin a trial
//   stop   1-cycle pulse, player response
//   clear  1-cycle pulse, abort / return to idle
//   led0   stimulus LED, high only while timing the response
//   bcd    response time, 4 BCD digits, [15:12] = thousands
//   mode   0 IDLE, 1 WAIT, 2 TIMING, 3 DONE, 4 EARLY, 5 TIMEOUT
//   busy   high in WAIT or TIMING
module reaction_ctrl #(
  parameter int CLK_PER_MS   = 100_000,
  parameter int MIN_DELAY_MS = 2000,
  parameter int RAND_BITS    = 12,
  parameter int MAX_MS       = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  output logic        led0,
  output logic [15:0] bcd,
  output logic [2:0]  mode,
  output logic        busy
);

  localparam int PW = $clog2(CLK_PER_MS);

  // State encodings equal the mode codes reported to the display.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_TIMING  = 3'd2,
    S_DONE    = 3'd3,
    S_EARLY   = 3'd4,
    S_TIMEOUT = 3'd5
  } state_t;

  state_t          state;
  state_t          nxt;
  logic [15:0]     lfsr;
  logic            lfsr_fb;
  logic [PW-1:0]   presc;
  logic            tick;
  logic [15:0]     delay_ms;
  logic [15:0]     dcnt;
  logic [13:0]     ms_cnt;
  logic [15:0]     bcd_inc;
  logic            carry;

  // Fibonacci LFSR, taps 16,14,13,11 (bit 0 is tap 16, shifting right).
  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  assign tick = (presc == PW'(CLK_PER_MS - 1));

  // Decimal increment of the four-digit display value.
  always_comb begin
    bcd_inc = bcd;
    carry   = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (carry) begin
        if (bcd[4*i +: 4] == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  // Next-state decode; clear overrides everything, stop overrides start
  // and overrides a same-cycle tick.
  always_comb begin
    nxt = state;
    if (clear) begin
      nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:   if (start) nxt = S_WAIT;
        S_WAIT: begin
          if (stop)                                   nxt = S_EARLY;
          else if (tick && (dcnt + 16'd1 == delay_ms)) nxt = S_TIMING;
        end
        S_TIMING: begin
          if (stop)                                          nxt = S_DONE;
          else if (tick && (ms_cnt + 14'd1 == 14'(MAX_MS)))  nxt = S_TIMEOUT;
        end
        default:  nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      lfsr     <= 16'hACE1;
      presc    <= '0;
      delay_ms <= '0;
      dcnt     <= '0;
      ms_cnt   <= '0;
      bcd      <= '0;
      led0     <= 1'b0;
      mode     <= 3'd0;
      busy     <= 1'b0;
    end else begin
      lfsr  <= {lfsr_fb, lfsr[15:1]};
      // Restarting the prescaler on every transition aligns ms ticks to
      // the moment a phase begins.
      presc <= (nxt != state || clear || tick) ? '0 : presc + 1'b1;
      state <= nxt;
      mode  <= nxt;
      led0  <= (nxt == S_TIMING);
      busy  <= (nxt == S_WAIT) || (nxt == S_TIMING);

      if (clear) begin
        bcd    <= '0;
        dcnt   <= '0;
        ms_cnt <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              delay_ms <= 16'(MIN_DELAY_MS) + 16'(lfsr[RAND_BITS-1:0]);
              bcd      <= '0;
              dcnt     <= '0;
              ms_cnt   <= '0;
            end
          end
          S_WAIT: begin
            if (stop)      bcd  <= 16'h9999;
            else if (tick) dcnt <= dcnt + 16'd1;
          end
          S_TIMING: begin
            // bcd tracks ms_cnt from zero, so on timeout it already shows MAX_MS.
            if (!stop && tick) begin
              bcd    <= bcd_inc;
              ms_cnt <= ms_cnt + 14'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reaction_ctrl.sv
module tb_reaction_ctrl;

  localparam int CPM   = 4;
  localparam int MIND  = 3;
  localparam int RB    = 2;
  localparam int MAXMS = 20;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop  = 1'b0;
  logic        clear = 1'b0;
  logic        led0;
  logic [15:0] bcd;
  logic [2:0]  mode;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;   // clock edges since reset release

  reaction_ctrl #(
    .CLK_PER_MS  (CPM),
    .MIN_DELAY_MS(MIND),
    .RAND_BITS   (RB),
    .MAX_MS      (MAXMS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .stop (stop),
    .clear(clear),
    .led0 (led0),
    .bcd  (bcd),
    .mode (mode),
    .busy (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  // ---------------- reference model helpers ----------------
  function automatic int lfsr_after(int n);
    int unsigned l;
    int unsigned b;
    l = 32'hACE1;
    for (int i = 0; i < n; i++) begin
      b = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
      l = (l >> 1) | (b << 15);
    end
    return int'(l);
  endfunction

  // Fore-period in ms for a start pulse sampled on the next clock edge.
  function automatic int model_delay();
    return MIND + (lfsr_after(cyc) % (1 << RB));
  endfunction

  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired", nm);
  endtask

  task automatic chk_out(input string tag, input logic [2:0] m, input logic [15:0] b,
                         input logic l, input logic bz);
    chk({tag, "_mode"}, 32'(mode), 32'(m));
    chk({tag, "_bcd"},  32'(bcd),  32'(b));
    chk({tag, "_led0"}, 32'(led0), 32'(l));
    chk({tag, "_busy"}, 32'(busy), 32'(bz));
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic s, input logic p, input logic c);
    start = s; stop = p; clear = c;
    step(1);
    start = 1'b0; stop = 1'b0; clear = 1'b0;
  endtask

  // Cycles from the start edge until led0 is seen high.
  task automatic wait_rise(input string nm, output int w, output bit ok);
    w = 0;
    while (led0 !== 1'b1 && w < 60) begin
      step(1);
      w++;
    end
    ok = (led0 === 1'b1);
    if (!ok) fail_now(nm);
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic s, p, c;
    logic [2:0]  m;
    logic [15:0] b;
    logic l, bz;
  } vec_t;

  vec_t vt[14];

  // ---------------- randomized trial ----------------
  task automatic trial(input int idx);
    int d, w, k, s;
    bit ok;
    logic [2:0]  em;
    logic [15:0] eb;
    string tg;
    tg = $sformatf("rnd%0d", idx);
    step($urandom_range(0, 5));
    d = model_delay();
    pulse(1, 0, 0);
    chk({tg, "_wait_mode"}, 32'(mode), 32'd1);
    if ($urandom_range(0, 3) == 0) begin
      s = $urandom_range(1, 4 * d - 2);   // stop sampled s edges after start
      step(s - 1);
      pulse(0, 1, 0);
      em = 3'd4; eb = 16'h9999;
    end else begin
      wait_rise({tg, "_rise"}, w, ok);
      if (!ok) begin
        pulse(0, 0, 1);
        return;
      end
      chk_rng({tg, "_delay"}, w, 4 * d - 1, 4 * d + 1);
      k = $urandom_range(0, 90);
      step(k);
      pulse(0, 1, 0);
      // Ticks land k' = 4,8,... edges after TIMING entry; stop is sampled k+1 after.
      if (k >= MAXMS * CPM) begin em = 3'd5; eb = to_bcd(MAXMS); end
      else                  begin em = 3'd3; eb = to_bcd(k / CPM); end
    end
    chk_out({tg, "_end"}, em, eb, 1'b0, 1'b0);
    step($urandom_range(0, 3));
    pulse(1, 1, 0);
    chk_out({tg, "_hold"}, em, eb, 1'b0, 1'b0);
    pulse(0, 0, 1);
    chk_out({tg, "_clr"}, 3'd0, 16'h0, 1'b0, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d1, c1, w1, w, d;
    bit ok;

    vt[0]  = '{1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 3'd1, 16'h0000, 1'b0, 1'b1};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 3'd1, 16'h0000, 1'b0, 1'b1};
    vt[3]  = '{1'b0, 1'b1, 1'b0, 3'd4, 16'h9999, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 3'd4, 16'h9999, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 1'b0, 3'd4, 16'h9999, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 1'b1, 3'd0, 16'h0000, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 1'b0, 3'd1, 16'h0000, 1'b0, 1'b1};
    vt[8]  = '{1'b0, 1'b0, 1'b1, 3'd0, 16'h0000, 1'b0, 1'b0};
    vt[9]  = '{1'b1, 1'b1, 1'b1, 3'd0, 16'h0000, 1'b0, 1'b0};
    vt[10] = '{1'b1, 1'b0, 1'b0, 3'd1, 16'h0000, 1'b0, 1'b1};
    vt[11] = '{1'b1, 1'b1, 1'b0, 3'd4, 16'h9999, 1'b0, 1'b0};
    vt[12] = '{1'b0, 1'b0, 1'b1, 3'd0, 16'h0000, 1'b0, 1'b0};
    vt[13] = '{1'b0, 1'b0, 1'b1, 3'd0, 16'h0000, 1'b0, 1'b0};

    // 1. reset then idle
    #22 reset = 1'b0;
    step(10);
    chk_out("reset_idle", 3'd0, 16'h0000, 1'b0, 1'b0);

    // 2. first trial: delay from the model LFSR, stop after 7 ticks
    d1 = model_delay();
    c1 = cyc;
    pulse(1, 0, 0);
    chk_out("t2_wait", 3'd1, 16'h0000, 1'b0, 1'b1);
    wait_rise("t2_rise", w1, ok);
    chk_rng("t2_delay", w1, 4 * d1 - 1, 4 * d1 + 1);
    chk_out("t2_timing", 3'd2, 16'h0000, 1'b1, 1'b1);
    step(29);
    pulse(0, 1, 0);
    chk_out("t2_done", 3'd3, 16'h0007, 1'b0, 1'b0);
    pulse(0, 0, 1);

    // 3. command table (early stop, ignored commands, priorities)
    for (int i = 0; i < 14; i++) begin
      pulse(vt[i].s, vt[i].p, vt[i].c);
      chk_out($sformatf("vec%0d", i), vt[i].m, vt[i].b, vt[i].l, vt[i].bz);
    end

    // 4. timeout with decimal carry
    pulse(1, 0, 0);
    wait_rise("t4_rise", w, ok);
    step(39);
    chk_out("t4_b9", 3'd2, 16'h0009, 1'b1, 1'b1);
    step(1);
    chk_out("t4_b10", 3'd2, 16'h0010, 1'b1, 1'b1);
    step(39);
    chk_out("t4_b19", 3'd2, 16'h0019, 1'b1, 1'b1);
    step(1);
    chk_out("t4_timeout", 3'd5, to_bcd(MAXMS), 1'b0, 1'b0);
    pulse(1, 1, 0);
    chk_out("t4_hold", 3'd5, to_bcd(MAXMS), 1'b0, 1'b0);
    pulse(0, 0, 1);
    chk_out("t4_clr", 3'd0, 16'h0000, 1'b0, 1'b0);

    // 5. stop coincident with tick #5; stop+clear together
    pulse(1, 0, 0);
    wait_rise("t5_rise", w, ok);
    step(19);
    pulse(0, 1, 0);
    chk_out("t5_coinc", 3'd3, 16'h0004, 1'b0, 1'b0);
    pulse(0, 0, 1);
    pulse(1, 0, 0);
    wait_rise("t5b_rise", w, ok);
    step(5);
    pulse(0, 1, 1);
    chk_out("t5_stopclr", 3'd0, 16'h0000, 1'b0, 1'b0);

    // randomized trials against the model
    for (int i = 0; i < 20; i++) trial(i);

    // 6. async reset mid-TIMING, then LFSR reseed
    pulse(1, 0, 0);
    wait_rise("t6_rise", w, ok);
    step(10);
    #3 reset = 1'b1;
    #1;
    chk_out("t6_async", 3'd0, 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    #4 reset = 1'b0;
    while (cyc < c1) step(1);
    d = model_delay();
    chk("t6_model_delay", 32'(d), 32'(d1));
    pulse(1, 0, 0);
    wait_rise("t6b_rise", w, ok);
    chk("t6_reseed", 32'(w), 32'(w1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
